program_counter_stack: RTL
==========================

# program_counter_stack

Parametrised program counter with a hardware return-address stack, generalising the team's 16-bit load/offset counter. Each cycle it selects the next instruction address from increment, signed relative branch, absolute load, subroutine call (push return address, jump) or return (pop). It sits between the control unit and instruction memory address port; all state changes are registered on one clock.

## Interface
- WIDTH, 16: counter, load value and stack entry width in bits
- OFFSET_W, 9: width of the signed branch offset; must be ≤ WIDTH
- DEPTH, 8: return-stack entries; power of two, ≥ 2
- RESET_VALUE, 0: CounterValue after reset
---
- Clock  input  1  system clock; all state changes on its rising edge
- nReset  input  1  synchronous, active-low reset
- Stall  input  1  hold all state this cycle
- LoadEnable  input  1  absolute jump to LoadValue
- LoadValue  input  WIDTH  jump/call target (signed)
- OffsetEnable  input  1  relative branch by Offset
- Offset  input  OFFSET_W  signed branch offset
- Call  input  1  push CounterValue+1, jump to LoadValue
- Return  input  1  pop stack top into CounterValue
- CounterValue  output  WIDTH  current PC (signed, registered)
- ReturnAddr  output  WIDTH  current stack top; 0 when empty
- StackDepth  output  $clog2(DEPTH)+1  valid entries, 0..DEPTH
- StackEmpty  output  1  StackDepth == 0
- StackFull  output  1  StackDepth == DEPTH
- StackError  output  2  only with PC_STACK_ERR_EN; bit0 overflow, bit1 underflow (sticky)
- ErrorClear  input  1  only with PC_STACK_ERR_EN; clears StackError

## Operation
- Next-state priority, highest first: nReset low > Stall > Return > Call > LoadEnable > OffsetEnable > increment.
- Reset: CounterValue = RESET_VALUE, StackDepth = 0, stack pointer = 0, StackError = 0. Stack RAM contents need not clear.
- Stall: CounterValue, stack, depth, error flags all hold; every other control ignored.
- Increment: CounterValue + 1.
- Offset: CounterValue + sign-extended Offset.
- Load: CounterValue = LoadValue.
- Call: write CounterValue+1 at stack pointer, pointer+1, depth+1 (saturating at DEPTH), CounterValue = LoadValue.
- Return, non-empty: CounterValue = ReturnAddr, pointer−1, depth−1.
- Return + Call same cycle: Return executes, Call dropped.
- Stack is circular: Call when full overwrites the oldest entry; depth stays DEPTH; the most recent DEPTH return addresses remain correct.
- Return when empty: treated as increment; pointer and depth unchanged.
- All additions modulo 2^WIDTH; wrap at 0x…FFFF → 0 is silent, no flag.

## Timing
- Every change lands on the rising Clock edge after the controls are sampled; latency one cycle.
- CounterValue, StackDepth, StackError are registers; StackEmpty, StackFull, ReturnAddr derived combinationally from registers only (no input-to-output combinational path).
- Back-to-back Calls/Returns every cycle supported; no bubbles.
- Reset mid-sequence (any cycle) discards the stack in that edge; the next cycle starts at RESET_VALUE with StackEmpty = 1.

## Configuration
- PC_STACK_ERR_EN defined: StackError and ErrorClear ports exist. Call while StackFull (not stalled, Return low) sets bit0; Return while StackEmpty sets bit1. Bits hold until ErrorClear or reset; ErrorClear has priority over a same-cycle set, is ignored while Stall is high. PC and stack behaviour identical to the non-macro build.
- Undefined: ports absent; overflow/underflow handled silently as in Operation.

## Test plan
- Reset/increment: nReset low 1 cycle, idle 4 cycles -> CounterValue 0,1,2,3,4; StackEmpty=1, StackDepth=0.
- Branch/load/wrap: PC=10, Offset=−3 -> 7; LoadValue=0xFFFF then idle -> 0xFFFF, 0x0000; Offset=+255 from 0 -> 255.
- Nested call/return: PC=0x20 Call→0x100, at 0x100 Call→0x200, Return, Return -> PC 0x100, 0x200, 0x101, 0x21; depth 1,2,1,0.
- Overflow (DEPTH=8): 9 Calls from PCs 0..8 -> StackFull, depth 8; 8 Returns yield 9,8,...,2; 9th Return -> PC+1, depth 0; with PC_STACK_ERR_EN StackError = 2'b11 until ErrorClear.
- Priority/stall: Return+Call+LoadEnable together with top=0x40 -> PC 0x40, depth−1; Stall high with Call -> PC, depth unchanged for held cycles.
- Reset mid-call: depth 3, nReset low during a Call -> next cycle PC=RESET_VALUE, depth 0, ReturnAddr 0.

Source files
------------

// File: rtl/program_counter_stack.sv
// Program counter with a circular hardware return-address stack: increment, relative branch,
// absolute load, call and return. Optional sticky overflow/underflow flags via PC_STACK_ERR_EN.
module program_counter_stack #(
   parameter int               WIDTH       = 16,
   parameter int               OFFSET_W    = 9,
   parameter int               DEPTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                    Clock,
   input  logic                    nReset,
   input  logic                    Stall,
   input  logic                    LoadEnable,
   input  logic [WIDTH-1:0]        LoadValue,
   input  logic                    OffsetEnable,
   input  logic [OFFSET_W-1:0]     Offset,
   input  logic                    Call,
   input  logic                    Return,
   output logic [WIDTH-1:0]        CounterValue,
   output logic [WIDTH-1:0]        ReturnAddr,
   output logic [$clog2(DEPTH):0]  StackDepth,
   output logic                    StackEmpty,
`ifdef PC_STACK_ERR_EN
   output logic [1:0]              StackError,
   input  logic                    ErrorClear,
`endif
   output logic                    StackFull
);

   localparam int                 PTR_W      = $clog2(DEPTH);
   localparam int                 DEPTH_W    = PTR_W + 1;
   localparam logic [DEPTH_W-1:0] FULL_DEPTH = DEPTH_W'(DEPTH);

   logic [WIDTH-1:0]   r_stack [DEPTH];
   logic [PTR_W-1:0]   r_sp;
   logic [DEPTH_W-1:0] r_depth;
   logic [WIDTH-1:0]   r_pc;

   logic [WIDTH-1:0]   w_pc_inc;
   logic [WIDTH-1:0]   w_pc_next;
   logic [WIDTH-1:0]   w_offset_ext;
   logic [WIDTH-1:0]   w_top;
   logic               w_empty;
   logic               w_full;
   logic               w_do_ret;
   logic               w_do_call;

   assign w_pc_inc     = r_pc + WIDTH'(1);
   assign w_offset_ext = WIDTH'($signed(Offset));
   // The pointer addresses the next free slot, so the top entry sits one below it.
   assign w_top        = r_stack[r_sp - PTR_W'(1)];
   assign w_empty      = (r_depth == '0);
   assign w_full       = (r_depth == FULL_DEPTH);
   // A Return on an empty stack degrades to increment; Return always suppresses Call.
   assign w_do_ret     = Return && !w_empty;
   assign w_do_call    = Call && !Return;

   assign CounterValue = r_pc;
   assign StackDepth   = r_depth;
   assign StackEmpty   = w_empty;
   assign StackFull    = w_full;
   assign ReturnAddr   = w_empty ? '0 : w_top;

   // NOTE: every signal driven here gets a default first so no latch is inferred.
   always_comb begin
      w_pc_next = w_pc_inc;
      if (Return) begin
         if (!w_empty) w_pc_next = w_top;
      end else if (Call || LoadEnable) begin
         w_pc_next = LoadValue;
      end else if (OffsetEnable) begin
         w_pc_next = r_pc + w_offset_ext;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge Clock) begin
      if (!nReset) begin
         r_pc    <= RESET_VALUE;
         r_sp    <= '0;
         r_depth <= '0;
      end else if (!Stall) begin
         r_pc <= w_pc_next;
         if (w_do_ret) begin
            r_sp    <= r_sp - PTR_W'(1);
            r_depth <= r_depth - DEPTH_W'(1);
         end else if (w_do_call) begin
            r_sp <= r_sp + PTR_W'(1);
            if (!w_full) r_depth <= r_depth + DEPTH_W'(1);
         end
      end
   end

   // NOTE: the stack RAM has no reset; depth and pointer alone define which entries are valid.
   always_ff @(posedge Clock) begin
      if (nReset && !Stall && w_do_call) r_stack[r_sp] <= w_pc_inc;
   end

`ifdef PC_STACK_ERR_EN
   logic [1:0] r_err;

   assign StackError = r_err;

   always_ff @(posedge Clock) begin
      if (!nReset) begin
         r_err <= '0;
      end else if (!Stall) begin
         if (ErrorClear) r_err <= '0;
         else            r_err <= r_err | {Return && w_empty, w_do_call && w_full};
      end
   end
`endif

endmodule
